// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM.
//   - state_e        : FSM state encoding (also exported on state_o)
//   - OP_*           : primary opcode constants (instruction bits [31:26])
//   - alu_op_e, reg_dst_e, mem_to_reg_e, alu_src_b_e, pc_src_e : mux/ALU encodings
//   - ctrl_out_t     : bundle of every control output driven by the decoder
//   - opcode_is_legal / decode_dispatch : opcode classification helpers
package mc_ctrl_pkg;

  localparam int OPCODE_W = 6;
  localparam int ALU_OP_W = 3;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_RTYPE = 3'b010,
    ALU_SLT   = 3'b011
  } alu_op_e;

  typedef enum logic [1:0] {
    RDST_RT = 2'd0,
    RDST_RD = 2'd1,
    RDST_RA = 2'd2
  } reg_dst_e;

  typedef enum logic [1:0] {
    M2R_ALUOUT = 2'd0,
    M2R_MDR    = 2'd1,
    M2R_PC     = 2'd2
  } mem_to_reg_e;

  typedef enum logic [1:0] {
    SRCB_RT     = 2'd0,
    SRCB_FOUR   = 2'd1,
    SRCB_IMM    = 2'd2,
    SRCB_IMM_SH = 2'd3
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2
  } pc_src_e;

  typedef struct packed {
    logic        pc_en;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_write;
    reg_dst_e    reg_dst;
    mem_to_reg_e mem_to_reg;
    logic        alu_src_a;
    alu_src_b_e  alu_src_b;
    alu_op_e     alu_op;
    pc_src_e     pc_src;
    logic        illegal;
  } ctrl_out_t;

  function automatic logic opcode_is_legal(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_J, OP_JAL, OP_ADDI, OP_SLTI: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // State entered after DECODE; undefined opcodes fall back to FETCH.
  function automatic state_e decode_dispatch(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_RTYPE:       return S_EXEC;
      OP_LW, OP_SW:   return S_MEMADR;
      OP_BEQ, OP_BNE: return S_BRANCH;
      OP_J, OP_JAL:   return S_JUMP;
      OP_ADDI,
      OP_SLTI:        return S_IEXEC;
      default:        return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational output decode for the multi-cycle control FSM.
// Moore decode of the state, except pc_en / ir_write which also look at
// mem_ready (FETCH) and zero (BRANCH).
// Ports:
//   state_i      current FSM state
//   opcode_i     instruction opcode (stable from DECODE through writeback)
//   zero_i       ALU zero flag
//   mem_ready_i  memory access completes this cycle
//   ctrl_o       full control-output bundle
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_e                state_i,
  input  logic [OPCODE_W-1:0]   opcode_i,
  input  logic                  zero_i,
  input  logic                  mem_ready_i,
  output ctrl_out_t             ctrl_o
);

  always_comb begin
    // NOTE: every field gets a default before the case so no path can leave
    // a field unassigned, which would infer a latch.
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_src    = PCSRC_ALU;
        // IR and PC update only when the fetch actually completes.
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_en     = mem_ready_i;
      end
      S_DECODE: begin
        // Precompute the branch target while the register file is read.
        ctrl_o.alu_src_b = SRCB_IMM_SH;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.illegal   = ~opcode_is_legal(opcode_i);
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = RDST_RT;
        ctrl_o.mem_to_reg = M2R_MDR;
      end
      S_MEMWR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.alu_op    = ALU_RTYPE;
      end
      S_RWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = RDST_RD;
        ctrl_o.mem_to_reg = M2R_ALUOUT;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.pc_src    = PCSRC_ALUOUT;
        ctrl_o.pc_en     = ((opcode_i == OP_BEQ) &  zero_i) |
                           ((opcode_i == OP_BNE) & ~zero_i);
      end
      S_JUMP: begin
        ctrl_o.pc_src = PCSRC_JUMP;
        ctrl_o.pc_en  = 1'b1;
        if (opcode_i == OP_JAL) begin
          // PC already holds PC+4, which is the link value.
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.reg_dst    = RDST_RA;
          ctrl_o.mem_to_reg = M2R_PC;
        end
      end
      S_IEXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = (opcode_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_IWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = RDST_RT;
        ctrl_o.mem_to_reg = M2R_ALUOUT;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for a shared-resource multi-cycle MIPS datapath.
// Sequences fetch / decode / execute / memory / writeback (3-5 cycles per
// instruction, plus one per memory wait cycle) and drives every datapath
// mux select and write enable. All outputs are forced to 0 while rst_i is high.
// Optional build macro: CTRL_PERF_CNT_EN adds cycle_cnt_o / instr_cnt_o.
// Ports:
//   clk_i, rst_i (sync, active-high)     opcode_i, zero_i, mem_ready_i
//   pc_en_o, iord_o, mem_read_o, mem_write_o, ir_write_o, reg_write_o
//   reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_src_o
//   illegal_o (one-cycle pulse on undefined opcode), state_o (debug)
//   [CTRL_PERF_CNT_EN] cycle_cnt_o, instr_cnt_o
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W    = OPCODE_W,
  parameter int ALUOP_W = ALU_OP_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    opcode_i,
  input  logic               zero_i,
  input  logic               mem_ready_i,
  output logic               pc_en_o,
  output logic               iord_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               ir_write_o,
  output logic               reg_write_o,
  output logic [1:0]         reg_dst_o,
  output logic [1:0]         mem_to_reg_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic [1:0]         pc_src_o,
  output logic               illegal_o,
  output logic [3:0]         state_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]        cycle_cnt_o,
  output logic [31:0]        instr_cnt_o
`endif
);

  state_e    state_q, state_d;
  ctrl_out_t dec_out, ctrl;

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // opcode_i comes straight from the instruction register, which holds it
  // stable from DECODE through writeback, so no internal copy is kept.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: state_d = decode_dispatch(opcode_i);
      S_MEMADR: state_d = (opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready_i ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready_i ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      default:  state_d = S_FETCH;   // writeback states and unreachable codes
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state_i     (state_q),
    .opcode_i    (opcode_i),
    .zero_i      (zero_i),
    .mem_ready_i (mem_ready_i),
    .ctrl_o      (dec_out)
  );

  // Gate with reset so an access interrupted by reset never fires a write
  // enable in the reset cycle.
  assign ctrl = rst_i ? '0 : dec_out;

  assign pc_en_o      = ctrl.pc_en;
  assign iord_o       = ctrl.iord;
  assign mem_read_o   = ctrl.mem_read;
  assign mem_write_o  = ctrl.mem_write;
  assign ir_write_o   = ctrl.ir_write;
  assign reg_write_o  = ctrl.reg_write;
  assign reg_dst_o    = ctrl.reg_dst;
  assign mem_to_reg_o = ctrl.mem_to_reg;
  assign alu_src_a_o  = ctrl.alu_src_a;
  assign alu_src_b_o  = ctrl.alu_src_b;
  assign alu_op_o     = ctrl.alu_op;
  assign pc_src_o     = ctrl.pc_src;
  assign illegal_o    = ctrl.illegal;
  assign state_o      = rst_i ? 4'd0 : state_q;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, instr_cnt_q;
  logic        instr_done;

  // An instruction retires when the FSM returns to FETCH, except the
  // DECODE->FETCH bounce taken for an undefined opcode.
  assign instr_done = (state_q != S_FETCH) && (state_d == S_FETCH) && !dec_out.illegal;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (instr_done) instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign instr_cnt_o = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: latency table, directed corner
// sequences and randomized instruction streams checked cycle by cycle against
// an instruction-level reference model (per-instruction state paths).
module tb_multicycle_ctrl;

  // State numbers as exported on state_o.
  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5;
  localparam int EXEC = 6, RWB = 7, BRANCH = 8, JUMP = 9, IEXEC = 10, IWB = 11;

  localparam logic [5:0] RT = 6'b000000, J = 6'b000010, JAL = 6'b000011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
  localparam logic [5:0] SLTI = 6'b001010, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BAD = 6'b111111;

  logic       clk_i = 1'b0;
  logic       rst_i, zero_i, mem_ready_i;
  logic [5:0] opcode_i;
  logic       pc_en_o, iord_o, mem_read_o, mem_write_o, ir_write_o, reg_write_o;
  logic [1:0] reg_dst_o, mem_to_reg_o, alu_src_b_o, pc_src_o;
  logic       alu_src_a_o, illegal_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_o, instr_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  multicycle_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .pc_en_o(pc_en_o), .iord_o(iord_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .ir_write_o(ir_write_o),
    .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .pc_src_o(pc_src_o), .illegal_o(illegal_o), .state_o(state_o)
`ifdef CTRL_PERF_CNT_EN
    , .cycle_cnt_o(cycle_cnt_o), .instr_cnt_o(instr_cnt_o)
`endif
  );

  typedef struct packed {
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal;
    logic [3:0] state;
  } obs_t;

  typedef struct { int st; bit rdy; } step_t;
  typedef struct { logic [5:0] op; int lat; string name; } vec_t;

  int n_checks = 0, n_fail = 0;
  int cyc_exp = 0, instr_exp = 0;
  logic [5:0] legal_ops [10] = '{RT, J, JAL, BEQ, BNE, ADDI, SLTI, LW, SW, RT};
  step_t path[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{pc_en_o, iord_o, mem_read_o, mem_write_o, ir_write_o, reg_write_o,
          reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o,
          pc_src_o, illegal_o, state_o};
    return o;
  endfunction

  // Expected control outputs for one cycle, straight from the state table.
  function automatic obs_t exp_obs(input int st, input logic [5:0] op, input bit z, input bit rdy);
    obs_t o;
    o = '0;
    o.state = 4'(st);
    case (st)
      FETCH:  begin o.mem_read = 1; o.alu_src_b = 1; o.ir_write = rdy; o.pc_en = rdy; end
      DECODE: begin o.alu_src_b = 3; o.illegal = !legal(op); end
      MEMADR: begin o.alu_src_a = 1; o.alu_src_b = 2; end
      MEMRD:  begin o.mem_read = 1; o.iord = 1; end
      MEMWB:  begin o.reg_write = 1; o.mem_to_reg = 1; end
      MEMWR:  begin o.mem_write = 1; o.iord = 1; end
      EXEC:   begin o.alu_src_a = 1; o.alu_op = 3'b010; end
      RWB:    begin o.reg_write = 1; o.reg_dst = 1; end
      BRANCH: begin
        o.alu_src_a = 1; o.alu_op = 3'b001; o.pc_src = 1;
        o.pc_en = (op == BEQ) ? z : (op == BNE) ? !z : 1'b0;
      end
      JUMP: begin
        o.pc_src = 2; o.pc_en = 1;
        if (op == JAL) begin o.reg_write = 1; o.reg_dst = 2; o.mem_to_reg = 2; end
      end
      IEXEC:  begin o.alu_src_a = 1; o.alu_src_b = 2; o.alu_op = (op == SLTI) ? 3'b011 : 3'b000; end
      IWB:    o.reg_write = 1;
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic do_step(input int st, input bit rdy, input logic [5:0] op, input string tag);
    bit   z;
    obs_t e;
    z = 1'($urandom_range(0, 1));
    opcode_i = op; mem_ready_i = rdy; zero_i = z;
    e = exp_obs(st, op, z, rdy);
    @(negedge clk_i);
    check($sformatf("%s st%0d", tag, st), 32'(sample()), 32'(e));
`ifdef CTRL_PERF_CNT_EN
    check($sformatf("%s cycle_cnt", tag), cycle_cnt_o, 32'(cyc_exp));
    check($sformatf("%s instr_cnt", tag), instr_cnt_o, 32'(instr_exp));
`endif
    @(posedge clk_i); #1;
    cyc_exp++;
  endtask

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference model: the sequence of steps an instruction walks through,
  // with fs fetch-wait cycles and ms data-memory wait cycles.
  task automatic run_instr(input logic [5:0] op, input int fs, input int ms, input string tag);
    path.delete();
    repeat (fs) path.push_back('{FETCH, 1'b0});
    path.push_back('{FETCH, 1'b1});
    path.push_back('{DECODE, rbit()});
    case (op)
      LW: begin
        path.push_back('{MEMADR, rbit()});
        repeat (ms) path.push_back('{MEMRD, 1'b0});
        path.push_back('{MEMRD, 1'b1});
        path.push_back('{MEMWB, rbit()});
      end
      SW: begin
        path.push_back('{MEMADR, rbit()});
        repeat (ms) path.push_back('{MEMWR, 1'b0});
        path.push_back('{MEMWR, 1'b1});
      end
      RT:          begin path.push_back('{EXEC, rbit()});  path.push_back('{RWB, rbit()}); end
      ADDI, SLTI:  begin path.push_back('{IEXEC, rbit()}); path.push_back('{IWB, rbit()}); end
      BEQ, BNE:    path.push_back('{BRANCH, rbit()});
      J, JAL:      path.push_back('{JUMP, rbit()});
      default:     ;
    endcase
    foreach (path[k]) do_step(path[k].st, path[k].rdy, op, tag);
    if (legal(op)) instr_exp++;
  endtask

  // Count edges from FETCH until the DUT is back in FETCH (bounded).
  task automatic measure_latency(input logic [5:0] op, input int lat, input string name);
    int n;
    n = 0;
    opcode_i = op; mem_ready_i = 1'b1; zero_i = 1'b0;
    do begin
      @(posedge clk_i); #1;
      n++; cyc_exp++;
    end while (state_o != 4'd0 && n < 20);
    check({name, " latency"}, 32'(n), 32'(lat));
    if (legal(op)) instr_exp++;
  endtask

  task automatic apply_reset(input int edges);
    rst_i = 1'b1; mem_ready_i = 1'b1;
    for (int i = 0; i < edges; i++) begin
      @(negedge clk_i);
      check("reset outputs", 32'(sample()), 32'd0);
      @(posedge clk_i); #1;
    end
    rst_i = 1'b0;
    cyc_exp = 0; instr_exp = 0;
  endtask

  vec_t vecs[10];

  initial begin
    vecs = '{
      '{LW, 5, "lw"},   '{SW, 4, "sw"},    '{RT, 4, "rtype"}, '{ADDI, 4, "addi"},
      '{SLTI, 4, "slti"}, '{BEQ, 3, "beq"}, '{BNE, 3, "bne"},  '{J, 3, "j"},
      '{JAL, 3, "jal"}, '{BAD, 2, "illegal"}
    };
    rst_i = 1'b1; opcode_i = '0; zero_i = 1'b0; mem_ready_i = 1'b1;

    apply_reset(3);
    @(negedge clk_i);
    check("post-reset state", 32'(state_o), 32'd0);
    check("post-reset mem_read", 32'(mem_read_o), 32'd1);
    @(posedge clk_i); #1;
    apply_reset(1);

    // Latency table with mem_ready tied high.
    for (int i = 0; i < 10; i++) measure_latency(vecs[i].op, vecs[i].lat, vecs[i].name);

    // Cycle-accurate walk of every instruction class.
    for (int i = 0; i < 10; i++) run_instr(vecs[i].op, 0, 0, vecs[i].name);

    // Directed corners.
    run_instr(LW, 0, 0, "lw seq");
    run_instr(SW, 2, 3, "sw stall");
    begin : beq_bne
      run_instr(BEQ, 0, 0, "beq pre");
      opcode_i = BEQ; mem_ready_i = 1; zero_i = 1;
      @(posedge clk_i); #1; cyc_exp++;          // FETCH -> DECODE
      @(posedge clk_i); #1; cyc_exp++;          // DECODE -> BRANCH
      @(negedge clk_i);
      check("beq z=1 pc_en", 32'({pc_en_o, pc_src_o}), 32'({1'b1, 2'd1}));
      @(posedge clk_i); #1; cyc_exp++; instr_exp++;
      opcode_i = BNE;
      @(posedge clk_i); #1; cyc_exp++;
      @(posedge clk_i); #1; cyc_exp++;
      @(negedge clk_i);
      check("bne z=1 pc_en", 32'(pc_en_o), 32'd0);
      @(posedge clk_i); #1; cyc_exp++; instr_exp++;
    end
    run_instr(JAL, 1, 0, "jal");
    run_instr(BAD, 0, 0, "illegal");
    run_instr(LW, 0, 1, "after illegal");

    // Reset in the middle of a stalled store: no write enable in that cycle.
    do_step(FETCH, 1'b1, SW, "mid-rst");
    do_step(DECODE, 1'b0, SW, "mid-rst");
    do_step(MEMADR, 1'b0, SW, "mid-rst");
    apply_reset(1);
    run_instr(ADDI, 0, 0, "after mid-rst");

    // Randomized instruction stream.
    for (int i = 0; i < 300; i++) begin
      logic [5:0] op;
      if ($urandom_range(0, 3) == 0) op = 6'($urandom);
      else                           op = legal_ops[$urandom_range(0, 9)];
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), $sformatf("rnd%0d op%02h", i, op));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM that sequences a shared-resource MIPS datapath: one ALU, one unified memory port, one register file.
- Steps each instruction through fetch, decode, execute, memory and writeback over 3–5 cycles.
- Drives every datapath mux select and write enable, and stalls on a memory ready handshake.
- Replaces the combinational opcode decoder when the CPU moves from single-cycle to multi-cycle.

Parameters:
- OP_W, 6, opcode field width
- ALUOP_W, 3, width of alu_op_o sent to the ALU control block

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- opcode_i  in  6  instruction bits [31:26] from the instruction register
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory access completes this cycle
- pc_en_o  out  1  program counter write enable
- iord_o  out  1  memory address source: 0 = PC, 1 = ALUOut
- mem_read_o  out  1  memory read request
- mem_write_o  out  1  memory write request
- ir_write_o  out  1  instruction register load
- reg_write_o  out  1  register file write enable
- reg_dst_o  out  2  write register select: 0 = rt, 1 = rd, 2 = $31
- mem_to_reg_o  out  2  write data select: 0 = ALUOut, 1 = MDR, 2 = PC
- alu_src_a_o  out  1  ALU A select: 0 = PC, 1 = rs
- alu_src_b_o  out  2  ALU B select: 0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm << 2
- alu_op_o  out  3  ALU op: 000 add, 001 sub, 010 R-type (use funct), 011 slt
- pc_src_o  out  2  next PC select: 0 = ALU result, 1 = ALUOut, 2 = jump target
- illegal_o  out  1  one-cycle pulse on an undefined opcode
- state_o  out  4  current state, for debug

Behaviour:
- State encoding:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
  - EXEC = 6, RWB = 7, BRANCH = 8, JUMP = 9, IEXEC = 10, IWB = 11
- Reset: rst_i high at a clock edge forces FETCH. While rst_i is high, all outputs are 0, including state_o. Reset mid-access abandons the instruction; no write enable asserts in that cycle.
- Outputs are a Moore decode of the state, except pc_en_o and ir_write_o, which also depend on mem_ready_i and zero_i. Unlisted outputs are 0.
- FETCH:
  - Outputs: mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 1, alu_op = add, pc_src = 0.
  - ir_write and pc_en equal mem_ready_i.
  - Stay in FETCH while mem_ready_i = 0; go to DECODE when it is 1.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 3, alu_op = add (precomputes the branch target).
  - Next state by opcode:
    - 000000 → EXEC
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000100 (beq) or 000101 (bne) → BRANCH
    - 000010 (j) or 000011 (jal) → JUMP
    - 001000 (addi) or 001010 (slti) → IEXEC
    - anything else → FETCH, with illegal_o = 1 for this cycle only
- MEMADR:
  - Outputs: alu_src_a = 1, alu_src_b = 2, alu_op = add.
  - Next: MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read = 1, iord = 1. Stay until mem_ready_i = 1, then go to MEMWB.
- MEMWB: reg_write = 1, reg_dst = 0, mem_to_reg = 1. Next: FETCH.
- MEMWR: mem_write = 1, iord = 1. Stay until mem_ready_i = 1, then go to FETCH. mem_write_o stays high for the whole wait.
- EXEC: alu_src_a = 1, alu_src_b = 0, alu_op = 010. Next: RWB.
- RWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Next: FETCH.
- BRANCH:
  - Outputs: alu_src_a = 1, alu_src_b = 0, alu_op = sub, pc_src = 1.
  - pc_en = zero_i for beq, ~zero_i for bne.
  - Next: FETCH.
- JUMP:
  - Outputs: pc_src = 2, pc_en = 1.
  - For jal also: reg_write = 1, reg_dst = 2, mem_to_reg = 2. PC at this point already holds PC+4.
  - Next: FETCH.
- IEXEC: alu_src_a = 1, alu_src_b = 2, alu_op = add for addi, slt for slti. Next: IWB.
- IWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Next: FETCH.
- Opcode handling: the opcode is held in the instruction register, so opcode_i is stable from DECODE through writeback. The FSM uses opcode_i directly, without an internal copy.
- Latency with mem_ready_i tied to 1:
  - lw = 5 cycles
  - R-type, addi, slti, sw = 4 cycles
  - beq, bne, j, jal = 3 cycles
  - Each memory wait cycle adds 1.
- Unreachable states decode as FETCH on the next edge.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- When defined:
  - Adds outputs cycle_cnt_o [31:0] and instr_cnt_o [31:0], both cleared by reset.
  - cycle_cnt_o increments every non-reset cycle.
  - instr_cnt_o increments on every transition into FETCH from any non-FETCH state, excluding illegal-opcode returns.
  - Both counters wrap at 2^32.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - state encodings
  - opcode constants
  - alu_op, reg_dst, mem_to_reg, alu_src_b and pc_src encodings
- One sub-module, mc_ctrl_outdec: purely combinational decode from (state, opcode, zero, mem_ready) to the output vector.
- The parent module holds the state register and next-state logic.

Test Plan:
- Reset: hold rst_i = 1 for 3 edges with mem_ready_i = 1 → all outputs 0; first cycle after release: state_o = 0, mem_read_o = 1.
- lw, mem_ready_i = 1: opcode_i = 100011 → state sequence 0,1,2,3,4,0; reg_write_o = 1 only in state 4, with mem_to_reg_o = 1.
- Memory stall: sw with mem_ready_i = 0 for 3 cycles in MEMWR → mem_write_o = 1 for 4 cycles, then FETCH; pc_en_o = 0 during the stalled fetch cycles.
- beq and bne: beq with zero_i = 1 → pc_en_o = 1, pc_src_o = 1 in BRANCH; bne with zero_i = 1 → pc_en_o = 0.
- jal: opcode_i = 000011 → in JUMP, reg_write_o = 1, reg_dst_o = 2, mem_to_reg_o = 2, pc_src_o = 2; instr_cnt_o increments by 1 when CTRL_PERF_CNT_EN is defined.
- Illegal opcode: opcode_i = 111111 in DECODE → illegal_o high for exactly 1 cycle, next state 0, no reg_write_o or mem_write_o asserted.
